// File: rtl/tlb_pkg.sv
// Shared types and constants for the fully associative TLB.
// Optional build macro used by tlb_lookup: TLB_MULTIHIT_CHK_EN.
package tlb_pkg;

  typedef struct packed {
    logic        e;
    logic [18:0] vppn;
    logic [5:0]  ps;
    logic        g;
    logic [9:0]  asid;
    logic [19:0] ppn0;
    logic [1:0]  plv0;
    logic [1:0]  mat0;
    logic        d0;
    logic        v0;
    logic [19:0] ppn1;
    logic [1:0]  plv1;
    logic [1:0]  mat1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  localparam logic [5:0] PS_4K = 6'd12;
  localparam logic [5:0] PS_4M = 6'd22;

  localparam logic [4:0] INVTLB_ALL       = 5'd0;
  localparam logic [4:0] INVTLB_ALL_ALT   = 5'd1;
  localparam logic [4:0] INVTLB_GLOBAL    = 5'd2;
  localparam logic [4:0] INVTLB_NONGLOBAL = 5'd3;
  localparam logic [4:0] INVTLB_ASID      = 5'd4;
  localparam logic [4:0] INVTLB_ASID_VA   = 5'd5;
  localparam logic [4:0] INVTLB_GASID_VA  = 5'd6;

endpackage

// File: rtl/tlb_match.sv
// Single-entry comparator: VA match by page size, full hit with e and ASID/global,
// and odd/even half select. Used for both search and invalidate compares.
module tlb_match
  import tlb_pkg::*;
(
  input  tlb_entry_t  entry,
  input  logic [18:0] vppn,
  input  logic [9:0]  asid,
  input  logic        va_bit12,
  output logic        hit,
  output logic        va_hit,
  output logic        odd
);

  // Only 4K and 4M pages are legal; any other ps never matches.
  always_comb begin
    va_hit = 1'b0;
    if (entry.ps == PS_4K)
      va_hit = (entry.vppn == vppn);
    else if (entry.ps == PS_4M)
      va_hit = (entry.vppn[18:9] == vppn[18:9]);
  end

  assign odd = (entry.ps == PS_4M) ? vppn[8] : va_bit12;
  assign hit = entry.e && (entry.g || (entry.asid == asid)) && va_hit;

endmodule

// File: rtl/tlb_lookup.sv
// Fully associative TLB: registered search, write, combinational read, bulk invalidate.
// Define TLB_MULTIHIT_CHK_EN to enable the registered s_multihit detector.
module tlb_lookup
  import tlb_pkg::*;
#(
  parameter  int TLBNUM = 16,
  localparam int IDXW   = $clog2(TLBNUM)
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            s_valid,
  input  logic            s_stall,
  input  logic [18:0]     s_vppn,
  input  logic            s_va_bit12,
  input  logic [9:0]      s_asid,
  output logic [19:0]     pfn,
  output logic            tlb_ne,
  output logic [IDXW-1:0] s_index,
  output logic            s_v,
  output logic            s_d,
  output logic [1:0]      s_plv,
  output logic [1:0]      s_mat,
  output logic            s_multihit,
  input  logic            we,
  input  logic [IDXW-1:0] w_index,
  input  tlb_entry_t      w_entry,
  input  logic [IDXW-1:0] r_index,
  output tlb_entry_t      r_entry,
  input  logic            inv_valid,
  input  logic [4:0]      inv_op,
  input  logic [9:0]      inv_asid,
  input  logic [18:0]     inv_vppn
);

  tlb_entry_t entries [TLBNUM];

  logic [TLBNUM-1:0] s_hit;
  logic [TLBNUM-1:0] s_odd;
  logic [TLBNUM-1:0] srch_va_unused;
  logic [TLBNUM-1:0] inv_hit;
  logic [TLBNUM-1:0] inv_va_hit;
  logic [TLBNUM-1:0] inv_odd_unused;
  logic [TLBNUM-1:0] inv_sel;

  for (genvar i = 0; i < TLBNUM; i++) begin : g_match
    tlb_match u_srch (
      .entry    (entries[i]),
      .vppn     (s_vppn),
      .asid     (s_asid),
      .va_bit12 (s_va_bit12),
      .hit      (s_hit[i]),
      .va_hit   (srch_va_unused[i]),
      .odd      (s_odd[i])
    );
    tlb_match u_inv (
      .entry    (entries[i]),
      .vppn     (inv_vppn),
      .asid     (inv_asid),
      .va_bit12 (1'b0),
      .hit      (inv_hit[i]),
      .va_hit   (inv_va_hit[i]),
      .odd      (inv_odd_unused[i])
    );
  end

  always_comb begin
    for (int i = 0; i < TLBNUM; i++) begin
      inv_sel[i] = 1'b0;
      case (inv_op)
        INVTLB_ALL, INVTLB_ALL_ALT: inv_sel[i] = 1'b1;
        INVTLB_GLOBAL:    inv_sel[i] = entries[i].g;
        INVTLB_NONGLOBAL: inv_sel[i] = !entries[i].g;
        INVTLB_ASID:      inv_sel[i] = !entries[i].g && (entries[i].asid == inv_asid);
        INVTLB_ASID_VA:   inv_sel[i] = !entries[i].g && (entries[i].asid == inv_asid)
                                       && inv_va_hit[i];
        INVTLB_GASID_VA:  inv_sel[i] = inv_hit[i];
        default:          inv_sel[i] = 1'b0;
      endcase
    end
  end

  // A write to an index overrides any invalidate hitting the same index.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < TLBNUM; i++) entries[i] <= '0;
    end else begin
      for (int i = 0; i < TLBNUM; i++) begin
        if (we && (w_index == IDXW'(i)))
          entries[i] <= w_entry;
        else if (inv_valid && inv_sel[i])
          entries[i].e <= 1'b0;
      end
    end
  end

  assign r_entry = entries[r_index];

  // Descending scan so the lowest matching index wins.
  logic [IDXW-1:0] hit_idx;
  logic            any_hit;
  always_comb begin
    hit_idx = '0;
    any_hit = 1'b0;
    for (int i = TLBNUM - 1; i >= 0; i--) begin
      if (s_hit[i]) begin
        hit_idx = IDXW'(i);
        any_hit = 1'b1;
      end
    end
  end

  tlb_entry_t  hit_e;
  logic        hit_odd;
  logic [19:0] sel_ppn;
  logic [19:0] nxt_pfn;
  logic [IDXW-1:0] nxt_idx;
  logic        nxt_ne, nxt_v, nxt_d;
  logic [1:0]  nxt_plv, nxt_mat;

  assign hit_e   = entries[hit_idx];
  assign hit_odd = s_odd[hit_idx];

  always_comb begin
    nxt_ne  = 1'b1;
    nxt_pfn = '0;
    nxt_idx = '0;
    nxt_v   = 1'b0;
    nxt_d   = 1'b0;
    nxt_plv = '0;
    nxt_mat = '0;
    sel_ppn = hit_odd ? hit_e.ppn1 : hit_e.ppn0;
    if (s_valid && any_hit) begin
      nxt_ne  = 1'b0;
      nxt_idx = hit_idx;
      nxt_v   = hit_odd ? hit_e.v1   : hit_e.v0;
      nxt_d   = hit_odd ? hit_e.d1   : hit_e.d0;
      nxt_plv = hit_odd ? hit_e.plv1 : hit_e.plv0;
      nxt_mat = hit_odd ? hit_e.mat1 : hit_e.mat0;
      nxt_pfn = (hit_e.ps == PS_4M) ? {sel_ppn[19:10], s_vppn[8:0], s_va_bit12} : sel_ppn;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      tlb_ne  <= 1'b1;
      pfn     <= '0;
      s_index <= '0;
      s_v     <= 1'b0;
      s_d     <= 1'b0;
      s_plv   <= '0;
      s_mat   <= '0;
    end else if (!s_stall) begin
      tlb_ne  <= nxt_ne;
      pfn     <= nxt_pfn;
      s_index <= nxt_idx;
      s_v     <= nxt_v;
      s_d     <= nxt_d;
      s_plv   <= nxt_plv;
      s_mat   <= nxt_mat;
    end
  end

`ifdef TLB_MULTIHIT_CHK_EN
  // Clearing the lowest set bit leaves something only when two or more entries hit.
  localparam logic [TLBNUM-1:0] ONE = {{(TLBNUM-1){1'b0}}, 1'b1};
  logic nxt_multi;
  assign nxt_multi = s_valid && (|(s_hit & (s_hit - ONE)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)
      s_multihit <= 1'b0;
    else if (!s_stall)
      s_multihit <= nxt_multi;
  end
`else
  assign s_multihit = 1'b0;
`endif

endmodule

// File: tb/tb_tlb_lookup.sv
// Scoreboard bench for tlb_lookup: driver queues expected responses, monitor checks them.
module tb_tlb_lookup;
  import tlb_pkg::*;

  localparam int TLBNUM = 16;
  localparam int IDXW   = 4;
`ifdef TLB_MULTIHIT_CHK_EN
  localparam logic MH = 1'b1;
`else
  localparam logic MH = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            resetn;
  logic            s_valid, s_stall, s_va_bit12;
  logic [18:0]     s_vppn;
  logic [9:0]      s_asid;
  logic [19:0]     pfn;
  logic            tlb_ne;
  logic [IDXW-1:0] s_index;
  logic            s_v, s_d, s_multihit;
  logic [1:0]      s_plv, s_mat;
  logic            we;
  logic [IDXW-1:0] w_index, r_index;
  tlb_entry_t      w_entry, r_entry;
  logic            inv_valid;
  logic [4:0]      inv_op;
  logic [9:0]      inv_asid;
  logic [18:0]     inv_vppn;

  always #5 clk = ~clk;

  tlb_lookup #(.TLBNUM(TLBNUM)) dut (
    .clk(clk), .resetn(resetn),
    .s_valid(s_valid), .s_stall(s_stall), .s_vppn(s_vppn),
    .s_va_bit12(s_va_bit12), .s_asid(s_asid),
    .pfn(pfn), .tlb_ne(tlb_ne), .s_index(s_index), .s_v(s_v), .s_d(s_d),
    .s_plv(s_plv), .s_mat(s_mat), .s_multihit(s_multihit),
    .we(we), .w_index(w_index), .w_entry(w_entry),
    .r_index(r_index), .r_entry(r_entry),
    .inv_valid(inv_valid), .inv_op(inv_op), .inv_asid(inv_asid), .inv_vppn(inv_vppn)
  );

  typedef struct packed {
    logic        ne;
    logic [19:0] pfn;
    logic [3:0]  idx;
    logic        v;
    logic        d;
    logic [1:0]  plv;
    logic [1:0]  mat;
    logic        multi;
  } rsp_t;

  rsp_t sb[$];
  logic check_next = 1'b0;
  int   errors = 0;
  int   checks = 0;

  tlb_entry_t e1, e2, e3, e5, e7;

  function automatic rsp_t hitRsp(input logic [19:0] p, input logic [3:0] idx,
                                  input logic v, input logic d,
                                  input logic [1:0] plv, input logic [1:0] mat,
                                  input logic multi);
    return {1'b0, p, idx, v, d, plv, mat, multi};
  endfunction

  function automatic rsp_t missRsp();
    return {1'b1, 31'b0};
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [18:0] vppn, input logic b12, input logic [9:0] asid,
                               input logic stall, input rsp_t exp);
    @(negedge clk);
    we        = 1'b0;
    inv_valid = 1'b0;
    s_valid   = 1'b1;
    s_stall   = stall;
    s_vppn    = vppn;
    s_va_bit12 = b12;
    s_asid    = asid;
    sb.push_back(exp);
    check_next = 1'b1;
  endtask

  task automatic idle();
    @(negedge clk);
    s_valid    = 1'b0;
    s_stall    = 1'b0;
    we         = 1'b0;
    inv_valid  = 1'b0;
    check_next = 1'b0;
  endtask

  task automatic writeEntry(input logic [3:0] idx, input tlb_entry_t ent);
    @(negedge clk);
    s_valid    = 1'b0;
    check_next = 1'b0;
    we         = 1'b1;
    w_index    = idx;
    w_entry    = ent;
    idle();
  endtask

  // Monitor: a response is due on every edge where the driver flagged a check.
  initial begin : monitor
    rsp_t act;
    rsp_t exp;
    logic due;
    forever begin
      @(posedge clk);
      due = check_next;
      #1;
      if (due) begin
        act = {tlb_ne, pfn, s_index, s_v, s_d, s_plv, s_mat, s_multihit};
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL sb_underflow: got response %0h, expected none queued", act);
        end else begin
          exp = sb.pop_front();
          checkOutput("search_rsp", 64'(act), 64'(exp));
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    resetn = 1'b0;
    s_valid = 1'b0; s_stall = 1'b0; s_vppn = '0; s_va_bit12 = 1'b0; s_asid = '0;
    we = 1'b0; w_index = '0; w_entry = '0; r_index = '0;
    inv_valid = 1'b0; inv_op = '0; inv_asid = '0; inv_vppn = '0;

    e3 = '0; e3.e = 1; e3.ps = PS_4K; e3.asid = 10'd5; e3.vppn = 19'h00ABC;
    e3.ppn0 = 20'h11111; e3.v0 = 1; e3.ppn1 = 20'h22222; e3.v1 = 1;
    e3.d1 = 1; e3.plv1 = 2'd3; e3.mat1 = 2'd1;
    e7 = '0; e7.e = 1; e7.ps = PS_4M; e7.g = 1; e7.vppn = 19'h40000;
    e7.ppn0 = 20'hABC00; e7.v0 = 1; e7.ppn1 = 20'hDEF00; e7.v1 = 1;
    e2 = '0; e2.e = 1; e2.ps = PS_4K; e2.asid = 10'd5; e2.vppn = 19'h00222;
    e2.ppn0 = 20'h12345; e2.v0 = 1;
    e1 = '0; e1.e = 1; e1.ps = PS_4K; e1.g = 1; e1.vppn = 19'h00300;
    e1.ppn0 = 20'h33333; e1.v0 = 1;
    e5 = '0; e5.e = 1; e5.ps = PS_4K; e5.g = 1; e5.vppn = 19'h00500;
    e5.ppn0 = 20'h55555; e5.v0 = 1;

    repeat (2) @(negedge clk);
    checkOutput("reset_ne", 64'(tlb_ne), 64'd1);
    checkOutput("reset_pfn", 64'(pfn), 64'd0);
    checkOutput("reset_multihit", 64'(s_multihit), 64'd0);
    resetn = 1'b1;

    applyStimulus(19'h01234, 1'b0, 10'd0, 1'b0, missRsp());
    idle();

    writeEntry(4'd3, e3);
    r_index = 4'd3;
    #1 checkOutput("read_idx3", 64'(r_entry), 64'(e3));
    applyStimulus(19'h00ABC, 1'b1, 10'd5, 1'b0, hitRsp(20'h22222, 4'd3, 1, 1, 2'd3, 2'd1, 0));
    applyStimulus(19'h00ABC, 1'b0, 10'd5, 1'b0, hitRsp(20'h11111, 4'd3, 1, 0, 2'd0, 2'd0, 0));
    applyStimulus(19'h00ABC, 1'b1, 10'd6, 1'b0, missRsp());
    idle();

    writeEntry(4'd7, e7);
    applyStimulus(19'h40005, 1'b1, 10'd9, 1'b0, hitRsp(20'hABC0B, 4'd7, 1, 0, 2'd0, 2'd0, 0));
    applyStimulus(19'h40105, 1'b0, 10'd9, 1'b0, hitRsp(20'hDEE0A, 4'd7, 1, 0, 2'd0, 2'd0, 0));
    @(negedge clk);
    s_valid = 1'b0;
    sb.push_back(missRsp());
    check_next = 1'b1;
    idle();

    // Invalidate non-global ASID 5 while writing idx 2 in the same cycle.
    @(negedge clk);
    we = 1'b1; w_index = 4'd2; w_entry = e2;
    inv_valid = 1'b1; inv_op = INVTLB_ASID; inv_asid = 10'd5;
    idle();
    r_index = 4'd3;
    #1 checkOutput("inv_idx3_e", 64'(r_entry.e), 64'd0);
    r_index = 4'd2;
    #1 checkOutput("read_idx2", 64'(r_entry), 64'(e2));
    applyStimulus(19'h00ABC, 1'b1, 10'd5, 1'b0, missRsp());
    applyStimulus(19'h00222, 1'b0, 10'd5, 1'b0, hitRsp(20'h12345, 4'd2, 1, 0, 2'd0, 2'd0, 0));
    applyStimulus(19'h40005, 1'b1, 10'd5, 1'b0, hitRsp(20'hABC0B, 4'd7, 1, 0, 2'd0, 2'd0, 0));
    idle();

    writeEntry(4'd1, e1);
    writeEntry(4'd4, e1);
    applyStimulus(19'h00300, 1'b0, 10'd0, 1'b0, hitRsp(20'h33333, 4'd1, 1, 0, 2'd0, 2'd0, MH));
    idle();

    // Search in the write cycle sees old contents; the next cycle sees the new entry.
    @(negedge clk);
    we = 1'b1; w_index = 4'd5; w_entry = e5;
    s_valid = 1'b1; s_stall = 1'b0; s_vppn = 19'h00500; s_va_bit12 = 1'b0; s_asid = 10'd0;
    sb.push_back(missRsp());
    check_next = 1'b1;
    applyStimulus(19'h00500, 1'b0, 10'd0, 1'b0, hitRsp(20'h55555, 4'd5, 1, 0, 2'd0, 2'd0, 0));
    idle();

    applyStimulus(19'h00300, 1'b0, 10'd0, 1'b0, hitRsp(20'h33333, 4'd1, 1, 0, 2'd0, 2'd0, MH));
    applyStimulus(19'h00ABC, 1'b1, 10'd5, 1'b1, hitRsp(20'h33333, 4'd1, 1, 0, 2'd0, 2'd0, MH));
    applyStimulus(19'h00222, 1'b0, 10'd5, 1'b1, hitRsp(20'h33333, 4'd1, 1, 0, 2'd0, 2'd0, MH));
    applyStimulus(19'h00500, 1'b0, 10'd0, 1'b1, hitRsp(20'h33333, 4'd1, 1, 0, 2'd0, 2'd0, MH));

    // Asynchronous reset while still stalled.
    @(posedge clk);
    #3;
    check_next = 1'b0;
    resetn = 1'b0;
    #1;
    checkOutput("async_rst_ne", 64'(tlb_ne), 64'd1);
    checkOutput("async_rst_pfn", 64'(pfn), 64'd0);
    checkOutput("async_rst_index", 64'(s_index), 64'd0);
    for (int i = 0; i < TLBNUM; i++) begin
      r_index = IDXW'(i);
      #1 checkOutput($sformatf("rst_entry_%0d", i), 64'(r_entry), 64'd0);
    end
    idle();
    idle();
    resetn = 1'b1;

    applyStimulus(19'h00300, 1'b0, 10'd0, 1'b0, missRsp());
    idle();
    repeat (3) idle();

    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL sb_leftover: got %0d unchecked, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tlb_lookup.md
# tlb_lookup

Fully associative TLB that produces the `pfn` and `tlb_ne` inputs consumed by the address-translation stage. It accepts one search request per cycle and returns a registered result one cycle later. It also provides a write port (TLBWR/TLBFILL), a combinational read port (TLBRD) and a single-cycle bulk invalidate (INVTLB). Entries are held in flops; the block sits between the AGU/fetch-address register and the translation stage.

## Interface
- `TLBNUM`, 16: entry count, power of two, 2..64.
- `IDXW`, `$clog2(TLBNUM)`: index width (derived localparam).
- `clk` input 1: clock.
- `resetn` input 1: asynchronous active-low reset.
- `s_valid` input 1: search request.
- `s_stall` input 1: hold registered search outputs.
- `s_vppn` input 19: VA[31:13].
- `s_va_bit12` input 1: VA[12].
- `s_asid` input 10: current ASID.
- `pfn` output 20: physical frame, already merged for 4M pages.
- `tlb_ne` output 1: no matching entry.
- `s_index` output IDXW: hit index.
- `s_v`, `s_d` output 1 each: selected half valid and dirty.
- `s_plv` output 2, `s_mat` output 2: selected half attributes.
- `s_multihit` output 1: more than one entry matched.
- `we` input 1, `w_index` input IDXW, `w_entry` input `tlb_entry_t`: entry write.
- `r_index` input IDXW, `r_entry` output `tlb_entry_t`: combinational read.
- `inv_valid` input 1, `inv_op` input 5, `inv_asid` input 10, `inv_vppn` input 19: invalidate.

## Operation
- Entry match requires all of:
  - `e == 1`;
  - `g || asid == s_asid`;
  - for `ps == 12`, `vppn[18:0]` equal; for `ps == 22`, `vppn[18:9]` equal.
- Odd-page select is `s_va_bit12` when `ps == 12`, and `s_vppn[8]` (VA[22]) when `ps == 22`.
- Selected half is `{ppn1, plv1, mat1, d1, v1}` if odd, else `{ppn0, …}`.
- `pfn` output:
  - `ps == 12`: `ppn`.
  - `ps == 22`: `{ppn[19:10], s_vppn[8:0], s_va_bit12}`.
- Multiple hits select the lowest matching index.
- Miss: `tlb_ne = 1`, `pfn = 0`, `s_index = 0`, and all attributes 0.
- Write: when `we` is high, `entry[w_index] <= w_entry` at the clock edge.
- Read: `r_entry = entry[r_index]`, purely combinational.
- INVTLB clears `e` at the edge for each entry selected by `inv_op`:
  - 0 or 1: all entries.
  - 2: `g == 1`.
  - 3: `g == 0`.
  - 4: `g == 0 && asid == inv_asid`.
  - 5: op 4 conditions plus VA match.
  - 6: `(g || asid == inv_asid)` and VA match.
  - VA match uses the same ps rule as search, applied to `inv_vppn`.
  - Ops 7–31: no effect.
- `we` and `inv_valid` in the same cycle: the write wins for `w_index`, and the invalidate applies to all other entries.

## Timing
- Search latency is 1 cycle. Compare is combinational on the request inputs and the current array; the result is registered.
- Outputs update at the edge after `s_valid` when `s_stall == 0`.
- `s_valid == 0` with `s_stall == 0` registers the miss values (`tlb_ne = 1`).
- `s_stall == 1` holds all search outputs regardless of `s_valid`.
- A search in the same cycle as a write or invalidate compares against pre-edge contents. A search in the following cycle sees the new contents.
- Reset, including mid-operation:
  - all `e = 0`, all other entry fields 0;
  - `tlb_ne = 1`;
  - `pfn`, `s_index`, `s_v`, `s_d`, `s_plv`, `s_mat`, `s_multihit` = 0.
- `r_entry` follows the array with zero latency after reset.

## Configuration
- `TLB_MULTIHIT_CHK_EN` defined: the registered `s_multihit` is 1 when two or more entries match a valid, non-stalled search.
- Not defined: `s_multihit` is tied to 0 and the popcount logic is omitted. Hit selection is unchanged.

## Structure
- Package `tlb_pkg` holds:
  - `tlb_entry_t`, a packed struct: `e, vppn[18:0], ps[5:0], g, asid[9:0], ppn0[19:0], plv0[1:0], mat0[1:0], d0, v0, ppn1[19:0], plv1[1:0], mat1[1:0], d1, v1`;
  - `PS_4K = 6'd12`, `PS_4M = 6'd22`;
  - `INVTLB_*` op constants.
- Sub-module `tlb_match`: one entry in, plus `vppn`/`asid`/mode in; outputs `hit`, `va_hit` and `odd`. It is instantiated `TLBNUM` times for search and reused for the invalidate VA compare.

## Test plan
- Reset, then search `s_vppn = 19'h1234` → next cycle `tlb_ne = 1`, `pfn = 0`, `s_multihit = 0`.
- Write idx 3: `e = 1`, `ps = 12`, `g = 0`, `asid = 5`, `vppn = 19'h00ABC`, `ppn0 = 20'h11111`, `ppn1 = 20'h22222`, `v0 = v1 = 1`.
  - Search asid 5, `s_va_bit12 = 1` → `pfn = 20'h22222`, `s_index = 3`, `tlb_ne = 0`.
  - Same search with asid 6 → `tlb_ne = 1`.
- Write idx 7: `ps = 22`, `g = 1`, `vppn = 19'h40000`, `ppn0 = 20'hABC00`. Search `s_vppn = 19'h40005`, `s_va_bit12 = 1` → `pfn = 20'hABC0B`, `s_index = 7`.
- INVTLB op 4 with `inv_asid = 5` and `we` on idx 2 in the same cycle → idx 3 cleared (`tlb_ne = 1` on re-search); idx 2 written; idx 7 (`g = 1`) still hits.
- Identical entries at idx 1 and idx 4 → `s_index = 1`. `s_multihit = 1` with `TLB_MULTIHIT_CHK_EN`, 0 without.
- `s_stall = 1` for 3 cycles while `s_vppn` changes → outputs hold the prior hit. Assert `resetn = 0` mid-stall → `tlb_ne = 1` immediately (asynchronous) and all entries read `e = 0`.
